// File: rtl/acorn_phase_ctrl.sv
// acorn_phase_ctrl: sequences ACORN AEAD phases and decodes per-step m/ca/cb/tag controls.
module acorn_phase_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   input  logic [11:0]  ad_len,
   input  logic [11:0]  pt_len,
   input  logic         din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         step_en,
   output logic         m_bit,
   output logic         ca,
   output logic         cb,
   output logic [2:0]   phase,
   output logic         tag_en,
   output logic         busy,
   output logic         done
);
   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_AD, S_AD_PAD, S_ENC, S_ENC_PAD, S_FINAL, S_DONE
   } state_t;
   state_t      r_state, w_next;
   logic [11:0] r_cnt, r_ad_len, r_pt_len;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_ad_len <= '0;
         r_pt_len <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? '0 : r_cnt + {11'd0, step_en};
         if (r_state == S_IDLE && start) begin
            r_ad_len <= ad_len;
            r_pt_len <= pt_len;
         end
      end
   end
   assign phase = r_state;
   assign busy  = r_state != S_IDLE;
   always_comb begin
      w_next    = r_state;
      step_en   = 1'b0;
      m_bit     = 1'b0;
      ca        = 1'b0;
      cb        = 1'b0;
      tag_en    = 1'b0;
      din_ready = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_IDLE: w_next = start ? S_INIT : S_IDLE;
         S_INIT: begin
            step_en = 1'b1;
            ca      = 1'b1;
            cb      = 1'b1;
            // key, then iv, then key repeated with the first bit of the third pass inverted
            m_bit   = (r_cnt < 12'd128) ? key[r_cnt[6:0]] :
                      (r_cnt < 12'd256) ? iv[r_cnt[6:0]] :
                      key[r_cnt[6:0]] ^ (r_cnt == 12'd256);
            if (r_cnt == 12'd1791) w_next = (r_ad_len == '0) ? S_AD_PAD : S_AD;
         end
         S_AD: begin
            din_ready = 1'b1;
            step_en   = din_valid;
            m_bit     = din & din_valid;
            ca        = din_valid;
            cb        = din_valid;
            if (din_valid && r_cnt == r_ad_len - 12'd1) w_next = S_AD_PAD;
         end
         S_AD_PAD: begin
            step_en = 1'b1;
            m_bit   = r_cnt == '0;
            ca      = ~r_cnt[7];
            cb      = 1'b1;
            if (r_cnt == 12'd255) w_next = (r_pt_len == '0) ? S_ENC_PAD : S_ENC;
         end
         S_ENC: begin
            din_ready = 1'b1;
            step_en   = din_valid;
            m_bit     = din & din_valid;
            ca        = din_valid;
            if (din_valid && r_cnt == r_pt_len - 12'd1) w_next = S_ENC_PAD;
         end
         S_ENC_PAD: begin
            step_en = 1'b1;
            m_bit   = r_cnt == '0;
            ca      = ~r_cnt[7];
            if (r_cnt == 12'd255) w_next = S_FINAL;
         end
         S_FINAL: begin
            step_en = 1'b1;
            ca      = 1'b1;
            cb      = 1'b1;
            tag_en  = r_cnt >= 12'd640;
            if (r_cnt == 12'd767) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end
endmodule

// File: doc/acorn_phase_ctrl.md
ACORN_PHASE_CTRL -- requirements
Module: acorn_phase_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  begin one AEAD operation; sampled only in IDLE.
REQ-004 key  input  128  key, bit i = key[i]; held stable by source for the whole operation.
REQ-005 iv  input  128  IV, bit i = iv[i]; held stable for the whole operation.
REQ-006 ad_len  input  12  associated-data length in bits, latched on accepted start.
REQ-007 pt_len  input  12  plaintext length in bits, latched on accepted start.
REQ-008 din  input  1  serial AD/plaintext bit.
REQ-009 din_valid  input  1  din holds a valid bit.
REQ-010 din_ready  output  1  controller consumes din this cycle if din_valid=1.
REQ-011 step_en  output  1  state-update enable to the 293-bit datapath.
REQ-012 m_bit  output  1  message bit for the current step.
REQ-013 ca  output  1  control bit ca for the current step.
REQ-014 cb  output  1  control bit cb for the current step.
REQ-015 phase  output  3  current state encoding (REQ-019).
REQ-016 tag_en  output  1  current step's keystream bit is a tag bit.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when the operation completes.

Function
REQ-019 FSM states, encoding: IDLE=0, INIT=1, AD=2, AD_PAD=3, ENC=4, ENC_PAD=5, FINAL=6, DONE=7.
REQ-020 A 12-bit step counter cnt counts steps taken in the current state; cleared on every state transition; increments only when step_en=1.
REQ-021 IDLE: step_en=0, din_ready=0; start=1 latches ad_len/pt_len and moves to INIT next cycle; start while busy is ignored.
REQ-022 INIT: step_en=1 every cycle, ca=1, cb=1; m_bit=key[cnt] for cnt 0..127, iv[cnt-128] for 128..255, key[cnt mod 128] for 256..1791, except cnt=256 gives key[0]^1; after cnt=1791 step go to AD (or AD_PAD if ad_len=0).
REQ-023 AD: din_ready=1; step_en=din_valid; m_bit=din; ca=1, cb=1; after step ad_len-1 go to AD_PAD.
REQ-024 AD_PAD: 256 steps, step_en=1 every cycle; m_bit=1 at cnt=0 else 0; ca=1 for cnt 0..127, 0 for 128..255; cb=1; then ENC (or ENC_PAD if pt_len=0).
REQ-025 ENC: din_ready=1; step_en=din_valid; m_bit=din; ca=1, cb=0; after step pt_len-1 go to ENC_PAD.
REQ-026 ENC_PAD: 256 steps; m_bit=1 at cnt=0 else 0; ca=1 for cnt 0..127, 0 for 128..255; cb=0; then FINAL.
REQ-027 FINAL: 768 steps, step_en=1; m_bit=0, ca=1, cb=1; tag_en=1 for cnt 640..767; then DONE.
REQ-028 DONE: step_en=0, done=1 for exactly one cycle, then IDLE.
REQ-029 m_bit, ca, cb, tag_en, din_ready, step_en are combinational decodes of state, cnt and din_valid; m_bit/ca/cb/tag_en are 0 whenever step_en=0.
REQ-030 din_valid=0 in AD/ENC stalls: step_en=0, cnt and state hold, no bit lost.
REQ-031 din_ready=0 outside AD/ENC; din_valid there is ignored.
REQ-032 With din_valid held high, total cycles from start sample to done pulse = 1792+ad_len+256+pt_len+256+768+1.

Reset
REQ-033 rst=1 at any time, including mid-operation, forces IDLE, cnt=0, latched lengths=0, all outputs 0 immediately (asynchronous) and holds while asserted.
REQ-034 First start is accepted on the first rising edge after rst deasserts.

Verification
REQ-035 ad_len=0, pt_len=0, start one cycle -> step_en high 3072 consecutive cycles, states INIT->AD_PAD->ENC_PAD->FINAL, done pulse one cycle later, tag_en high exactly 128 cycles.
REQ-036 key=all ones, iv=0 -> INIT m_bit =1 for cnt 0..127, 0 for 128..255, 0 at cnt 256, 1 at cnt 257..1791.
REQ-037 ad_len=8, pt_len=16, din_valid toggling every cycle -> exactly 8 AD and 16 ENC steps, ca/cb = 1/1 in AD, 1/0 in ENC, no din consumed while din_valid=0.
REQ-038 AD_PAD check -> m_bit=1 only on first step, ca falls to 0 after 128 steps, cb stays 1; ENC_PAD identical except cb=0.
REQ-039 rst pulsed at FINAL cnt=300 -> all outputs 0 same cycle, phase=0; new start then runs full sequence from INIT.
REQ-040 start asserted while busy -> ignored; lengths unchanged, sequence completes as originally timed.
